// File: rtl/radix4_seq_multiplier.sv
// Radix-4 sequential shift-add multiplier with valid/ready on both sides.
// Retires two multiplier bits per BUSY cycle. Signed operands are handled by
// multiplying magnitudes and negating the final sum when the signs differ.
//
// Handshake: a request transfers on a posedge where in_vld && in_rdy; a result
// transfers on a posedge where out_vld && out_rdy. in_rdy is high only in IDLE,
// and c/out_vld stay frozen in DONE until the result transfers.
module radix4_seq_multiplier #(
  parameter int A_W = 16,
  parameter int B_W = 4,
  localparam int RES_W = A_W + B_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             is_signed,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [RES_W-1:0] c,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int ITER  = (B_W + 1) / 2;
  localparam int MP_W  = 2 * ITER;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [RES_W-1:0]   mcand_q;   // magnitude of a, pre-shifted by 2k
  logic [MP_W-1:0]    mplier_q;  // magnitude of b, consumed two bits per cycle
  logic [RES_W-1:0]   acc_q;
  logic [RES_W-1:0]   c_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;

  logic [A_W-1:0]     a_abs;
  logic [B_W-1:0]     b_abs;
  logic [RES_W-1:0]   partial;
  logic [RES_W-1:0]   acc_sum;

  // Operand magnitudes and the current radix-4 partial product.
  always_comb begin
    a_abs   = (is_signed && a[A_W-1]) ? (~a + A_W'(1)) : a;
    b_abs   = (is_signed && b[B_W-1]) ? (~b + B_W'(1)) : b;
    partial = (mplier_q[0] ? mcand_q : '0) + (mplier_q[1] ? (mcand_q << 1) : '0);
    acc_sum = acc_q + partial;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_d   = state_q;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    busy      = 1'b0;
    dbg_state = state_q;
    case (state_q)
      S_IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) state_d = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        out_vld = 1'b1;
        if (out_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, accumulate in BUSY, publish on last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_vld) begin
            mcand_q  <= RES_W'(a_abs);
            mplier_q <= MP_W'(b_abs);
            neg_q    <= is_signed & (a[A_W-1] ^ b[B_W-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        S_BUSY: begin
          acc_q    <= acc_sum;
          mcand_q  <= mcand_q << 2;
          mplier_q <= mplier_q >> 2;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) c_q <= neg_q ? (~acc_sum + RES_W'(1)) : acc_sum;
        end
        default: ;
      endcase
    end
  end

  assign c = c_q;

endmodule
